// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive demultiplexer.
// Frame state, slot-counter width helper and the supported channel ceiling.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_CHANNELS = 16;

  function automatic int slot_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter for one TDM frame.
// Counts 0..CHANNELS-1 with an explicit wrap, so non-power-of-2 frames never overrun.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SW       = slot_w(CHANNELS)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          load_one,
  input  logic          incr,
  output logic [SW-1:0] slot,
  output logic          last
);

  assign last = (slot == SW'(CHANNELS - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      slot <= '0;
    end else if (load_one) begin
      slot <= SW'(1);
    end else if (incr) begin
      slot <= last ? '0 : slot + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: aligns on frame sync and steers each slot word
// from the shared lane to its own registered channel slice, one cycle later.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           Clock_In,
  input  logic                           Reset_In,
  input  logic                           Enable_In,
  input  logic                           Frame_Sync_In,
  input  logic                           Data_Valid_In,
  input  logic [DATA_WIDTH-1:0]          Data_In,
  output logic [CHANNELS*DATA_WIDTH-1:0] Channel_Data_Out,
  output logic [CHANNELS-1:0]            Channel_Valid_Out,
  output logic                           Frame_Done_Out,
  output logic                           Sync_Error_Out
);

  localparam int SW = slot_w(CHANNELS);

  state_t        state_q, state_d;
  logic [SW-1:0] slot;
  logic          last;
  logic          accept;
  logic          wr_en;
  logic [SW-1:0] wr_slot;
  logic          load_one;
  logic          incr;
  logic          done_d;
  logic          err_d;

  assign accept = Enable_In & Data_Valid_In;

  tdm_slot_counter #(
    .CHANNELS (CHANNELS)
  ) u_slot_counter (
    .clk      (Clock_In),
    .clear    (Reset_In),
    .load_one (load_one),
    .incr     (incr),
    .slot     (slot),
    .last     (last)
  );

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // A sync always restarts at slot 0; only a clean write to the last slot completes a frame.
  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    wr_slot  = '0;
    load_one = 1'b0;
    incr     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (accept) begin
      unique case (state_q)
        HUNT: begin
          if (Frame_Sync_In) begin
            wr_en    = 1'b1;
            load_one = 1'b1;
            state_d  = RUN;
          end
        end
        RUN: begin
          wr_en = 1'b1;
          if (Frame_Sync_In) begin
            err_d    = 1'b1;
            load_one = 1'b1;
          end else begin
            wr_slot = slot;
            incr    = 1'b1;
            if (last) begin
              done_d  = 1'b1;
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      Channel_Data_Out  <= '0;
      Channel_Valid_Out <= '0;
      Frame_Done_Out    <= 1'b0;
      Sync_Error_Out    <= 1'b0;
    end else begin
      Frame_Done_Out <= done_d;
      Sync_Error_Out <= err_d;
      for (int k = 0; k < CHANNELS; k++) begin
        Channel_Valid_Out[k] <= wr_en && (wr_slot == SW'(k));
        if (wr_en && (wr_slot == SW'(k))) begin
          Channel_Data_Out[k*DATA_WIDTH +: DATA_WIDTH] <= Data_In;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (CHANNELS=4, DATA_WIDTH=8): each scenario task plays a
// vector table and checks every output one cycle after each applied input.
module tb_tdm_demux;

  logic        Clock_In;
  logic        Reset_In;
  logic        Enable_In;
  logic        Frame_Sync_In;
  logic        Data_Valid_In;
  logic [7:0]  Data_In;
  logic [31:0] Channel_Data_Out;
  logic [3:0]  Channel_Valid_Out;
  logic        Frame_Done_Out;
  logic        Sync_Error_Out;

  int total = 0;
  int bad   = 0;

  tdm_demux #(
    .CHANNELS   (4),
    .DATA_WIDTH (8)
  ) dut (
    .Clock_In          (Clock_In),
    .Reset_In          (Reset_In),
    .Enable_In         (Enable_In),
    .Frame_Sync_In     (Frame_Sync_In),
    .Data_Valid_In     (Data_Valid_In),
    .Data_In           (Data_In),
    .Channel_Data_Out  (Channel_Data_Out),
    .Channel_Valid_Out (Channel_Valid_Out),
    .Frame_Done_Out    (Frame_Done_Out),
    .Sync_Error_Out    (Sync_Error_Out)
  );

  initial begin
    Clock_In = 1'b0;
    forever #5 Clock_In = ~Clock_In;
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic        vld;
    logic        sync;
    logic [7:0]  d;
    logic [31:0] xd;
    logic [3:0]  xv;
    logic        xdone;
    logic        xerr;
  } vec_t;

  function automatic vec_t mk(input logic rst, en, vld, sync, input logic [7:0] d,
                              input logic [31:0] xd, input logic [3:0] xv,
                              input logic xdone, xerr);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.sync = sync; v.d = d;
    v.xd = xd; v.xv = xv; v.xdone = xdone; v.xerr = xerr;
    return v;
  endfunction

  // Drives one cycle of input, then waits until just after the capturing edge.
  task automatic apply(input vec_t v);
    Reset_In      = v.rst;
    Enable_In     = v.en;
    Data_Valid_In = v.vld;
    Frame_Sync_In = v.sync;
    Data_In       = v.d;
    @(posedge Clock_In);
    #1;
  endtask

  task automatic test_reset();
    vec_t v[2];
    v[0] = mk(1, 1, 1, 1, 8'hFF, 32'h0, 4'b0000, 0, 0);
    v[1] = mk(1, 0, 0, 0, 8'h00, 32'h0, 4'b0000, 0, 0);
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if ({Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out} !==
          {v[i].xd, v[i].xv, v[i].xdone, v[i].xerr}) begin
        bad++;
        $display("FAIL reset[%0d] got data=%h vld=%b done=%b err=%b want data=%h vld=%b done=%b err=%b",
                 i, Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out,
                 v[i].xd, v[i].xv, v[i].xdone, v[i].xerr);
      end
    end
  endtask

  task automatic test_frame();
    vec_t v[5];
    v[0] = mk(0, 1, 1, 1, 8'hA0, 32'h000000A0, 4'b0001, 0, 0);
    v[1] = mk(0, 1, 1, 0, 8'hA1, 32'h0000A1A0, 4'b0010, 0, 0);
    v[2] = mk(0, 1, 1, 0, 8'hA2, 32'h00A2A1A0, 4'b0100, 0, 0);
    v[3] = mk(0, 1, 1, 0, 8'hA3, 32'hA3A2A1A0, 4'b1000, 1, 0);
    v[4] = mk(0, 1, 0, 0, 8'h00, 32'hA3A2A1A0, 4'b0000, 0, 0);
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if ({Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out} !==
          {v[i].xd, v[i].xv, v[i].xdone, v[i].xerr}) begin
        bad++;
        $display("FAIL frame[%0d] got data=%h vld=%b done=%b err=%b want data=%h vld=%b done=%b err=%b",
                 i, Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out,
                 v[i].xd, v[i].xv, v[i].xdone, v[i].xerr);
      end
    end
  endtask

  task automatic test_hunt();
    vec_t v[3];
    v[0] = mk(1, 0, 0, 0, 8'h00, 32'h0, 4'b0000, 0, 0);
    v[1] = mk(0, 1, 1, 0, 8'h11, 32'h0, 4'b0000, 0, 0);
    v[2] = mk(0, 1, 1, 0, 8'h22, 32'h0, 4'b0000, 0, 0);
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if ({Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out} !==
          {v[i].xd, v[i].xv, v[i].xdone, v[i].xerr}) begin
        bad++;
        $display("FAIL hunt[%0d] got data=%h vld=%b done=%b err=%b want data=%h vld=%b done=%b err=%b",
                 i, Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out,
                 v[i].xd, v[i].xv, v[i].xdone, v[i].xerr);
      end
    end
  endtask

  task automatic test_resync();
    vec_t v[7];
    v[0] = mk(0, 1, 1, 1, 8'h10, 32'h00000010, 4'b0001, 0, 0);
    v[1] = mk(0, 1, 1, 0, 8'h11, 32'h00001110, 4'b0010, 0, 0);
    v[2] = mk(0, 1, 1, 1, 8'h20, 32'h00001120, 4'b0001, 0, 1);
    v[3] = mk(0, 1, 1, 0, 8'h21, 32'h00002120, 4'b0010, 0, 0);
    v[4] = mk(0, 1, 1, 0, 8'h22, 32'h00222120, 4'b0100, 0, 0);
    v[5] = mk(0, 1, 1, 0, 8'h23, 32'h23222120, 4'b1000, 1, 0);
    v[6] = mk(0, 1, 0, 0, 8'h00, 32'h23222120, 4'b0000, 0, 0);
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if ({Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out} !==
          {v[i].xd, v[i].xv, v[i].xdone, v[i].xerr}) begin
        bad++;
        $display("FAIL resync[%0d] got data=%h vld=%b done=%b err=%b want data=%h vld=%b done=%b err=%b",
                 i, Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out,
                 v[i].xd, v[i].xv, v[i].xdone, v[i].xerr);
      end
    end
  endtask

  task automatic test_enable();
    vec_t v[7];
    v[0] = mk(0, 1, 1, 1, 8'hB0, 32'h232221B0, 4'b0001, 0, 0);
    v[1] = mk(0, 1, 1, 0, 8'hB1, 32'h2322B1B0, 4'b0010, 0, 0);
    v[2] = mk(0, 0, 1, 0, 8'hEE, 32'h2322B1B0, 4'b0000, 0, 0);
    v[3] = mk(0, 0, 1, 1, 8'hEE, 32'h2322B1B0, 4'b0000, 0, 0);
    v[4] = mk(0, 0, 1, 0, 8'hEE, 32'h2322B1B0, 4'b0000, 0, 0);
    v[5] = mk(0, 1, 1, 0, 8'hB2, 32'h23B2B1B0, 4'b0100, 0, 0);
    v[6] = mk(0, 1, 1, 0, 8'hB3, 32'hB3B2B1B0, 4'b1000, 1, 0);
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if ({Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out} !==
          {v[i].xd, v[i].xv, v[i].xdone, v[i].xerr}) begin
        bad++;
        $display("FAIL enable[%0d] got data=%h vld=%b done=%b err=%b want data=%h vld=%b done=%b err=%b",
                 i, Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out,
                 v[i].xd, v[i].xv, v[i].xdone, v[i].xerr);
      end
    end
  endtask

  task automatic test_valid_gaps();
    vec_t v[7];
    v[0] = mk(0, 1, 1, 1, 8'hC0, 32'hB3B2B1C0, 4'b0001, 0, 0);
    v[1] = mk(0, 1, 0, 1, 8'h55, 32'hB3B2B1C0, 4'b0000, 0, 0);
    v[2] = mk(0, 1, 1, 0, 8'hC1, 32'hB3B2C1C0, 4'b0010, 0, 0);
    v[3] = mk(0, 1, 0, 0, 8'h55, 32'hB3B2C1C0, 4'b0000, 0, 0);
    v[4] = mk(0, 1, 1, 0, 8'hC2, 32'hB3C2C1C0, 4'b0100, 0, 0);
    v[5] = mk(0, 1, 0, 0, 8'h55, 32'hB3C2C1C0, 4'b0000, 0, 0);
    v[6] = mk(0, 1, 1, 0, 8'hC3, 32'hC3C2C1C0, 4'b1000, 1, 0);
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if ({Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out} !==
          {v[i].xd, v[i].xv, v[i].xdone, v[i].xerr}) begin
        bad++;
        $display("FAIL gaps[%0d] got data=%h vld=%b done=%b err=%b want data=%h vld=%b done=%b err=%b",
                 i, Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out,
                 v[i].xd, v[i].xv, v[i].xdone, v[i].xerr);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    vec_t v[9];
    v[0] = mk(0, 1, 1, 1, 8'hD0, 32'hC3C2C1D0, 4'b0001, 0, 0);
    v[1] = mk(0, 1, 1, 0, 8'hD1, 32'hC3C2D1D0, 4'b0010, 0, 0);
    v[2] = mk(0, 1, 1, 0, 8'hD2, 32'hC3D2D1D0, 4'b0100, 0, 0);
    v[3] = mk(1, 1, 1, 0, 8'hD3, 32'h00000000, 4'b0000, 0, 0);
    v[4] = mk(0, 1, 1, 0, 8'h77, 32'h00000000, 4'b0000, 0, 0);
    v[5] = mk(0, 1, 1, 1, 8'hE0, 32'h000000E0, 4'b0001, 0, 0);
    v[6] = mk(0, 1, 1, 0, 8'hE1, 32'h0000E1E0, 4'b0010, 0, 0);
    v[7] = mk(0, 1, 1, 0, 8'hE2, 32'h00E2E1E0, 4'b0100, 0, 0);
    v[8] = mk(0, 1, 1, 0, 8'hE3, 32'hE3E2E1E0, 4'b1000, 1, 0);
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if ({Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out} !==
          {v[i].xd, v[i].xv, v[i].xdone, v[i].xerr}) begin
        bad++;
        $display("FAIL rst_mid[%0d] got data=%h vld=%b done=%b err=%b want data=%h vld=%b done=%b err=%b",
                 i, Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out,
                 v[i].xd, v[i].xv, v[i].xdone, v[i].xerr);
      end
    end
  endtask

  task automatic test_sync_on_last_slot();
    vec_t v[8];
    v[0] = mk(0, 1, 1, 1, 8'hF0, 32'hE3E2E1F0, 4'b0001, 0, 0);
    v[1] = mk(0, 1, 1, 0, 8'hF1, 32'hE3E2F1F0, 4'b0010, 0, 0);
    v[2] = mk(0, 1, 1, 0, 8'hF2, 32'hE3F2F1F0, 4'b0100, 0, 0);
    v[3] = mk(0, 1, 1, 1, 8'hF3, 32'hE3F2F1F3, 4'b0001, 0, 1);
    v[4] = mk(0, 1, 1, 0, 8'h31, 32'hE3F231F3, 4'b0010, 0, 0);
    v[5] = mk(0, 1, 1, 0, 8'h32, 32'hE33231F3, 4'b0100, 0, 0);
    v[6] = mk(0, 1, 1, 0, 8'h33, 32'h333231F3, 4'b1000, 1, 0);
    v[7] = mk(0, 1, 1, 0, 8'h44, 32'h333231F3, 4'b0000, 0, 0);
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if ({Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out} !==
          {v[i].xd, v[i].xv, v[i].xdone, v[i].xerr}) begin
        bad++;
        $display("FAIL last_sync[%0d] got data=%h vld=%b done=%b err=%b want data=%h vld=%b done=%b err=%b",
                 i, Channel_Data_Out, Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out,
                 v[i].xd, v[i].xv, v[i].xdone, v[i].xerr);
      end
    end
  endtask

  initial begin
    Reset_In      = 1'b1;
    Enable_In     = 1'b0;
    Frame_Sync_In = 1'b0;
    Data_Valid_In = 1'b0;
    Data_In       = 8'h00;
    test_reset();
    test_frame();
    test_hunt();
    test_resync();
    test_enable();
    test_valid_gaps();
    test_reset_mid_frame();
    test_sync_on_last_slot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
